cpu_commit_redirect: RTL and testbench
======================================

// Module: cpu_commit_redirect
// PURPOSE
//  Commit-side source of the branch-redirect interface consumed by the fetch stage.
//  Sits at the end of execute and takes the retiring instruction's branch info and ALU zero flag.
//  Produces the registered redirect fields commit_branch / commit_zero / branch_result for fetch.
//  Squashes wrong-path instructions in decode/execute with a timed flush.
// PARAMETERS
//  ADDR_W       32  PC / branch target width (bits)
//  FLUSH_DEPTH   2  cycles flush stays high after a taken branch (>=1; wrong-path slots in DEC+EX)
//  CNT_W         8  width of the taken-redirect statistics counter
// PORTS
//  clock           in   1       pipeline clock, all state on rising edge
//  reset           in   1       synchronous, active-low (0 = reset)
//  ex_valid        in   1       execute presents a retiring instruction this cycle
//  ex_branch       in   1       retiring instruction is a conditional branch
//  ex_zero         in   1       ALU zero flag of the retiring instruction
//  ex_pc           in   ADDR_W  PC of the retiring instruction
//  ex_imm          in   ADDR_W  sign-extended word offset of the branch
//  commit_branch   out  1       redirect strobe to fetch (branch retired)
//  commit_zero     out  1       branch condition true (taken when commit_branch=1)
//  branch_result   out  ADDR_W  branch target for fetch
//  flush           out  1       squash younger instructions in decode/execute
//  redirect_count  out  CNT_W   number of taken redirects since reset, saturating
// BEHAVIOUR
//  - Reset (reset==0 at clock edge):
//    - All outputs go to 0 and state goes to IDLE; applies on the cycle reset is sampled.
//    - Reset during FLUSH aborts the flush immediately; no partial redirect remains.
//  - Target computation: target = ex_pc + 4 + (ex_imm << 2), modulo 2^ADDR_W.
//    - Wrap-around is silent; carry out is dropped.
//  - State IDLE, on an edge with ex_valid=1 (latency 1: outputs are registered):
//    - ex_branch=0: commit_branch=0 and commit_zero=0 next cycle; branch_result holds its old value.
//    - ex_branch=1, ex_zero=0 (not taken): for exactly 1 cycle, commit_branch=1, commit_zero=0,
//      branch_result=target. No flush; state stays IDLE.
//    - ex_branch=1, ex_zero=1 (taken): for exactly 1 cycle, commit_branch=1, commit_zero=1,
//      branch_result=target.
//      - flush=1 starting that same cycle; go to FLUSH with cnt=FLUSH_DEPTH-1.
//      - redirect_count increments by 1; it saturates at 2^CNT_W-1 and never wraps.
//  - State IDLE, ex_valid=0: commit_branch=0 and commit_zero=0 next cycle.
//  - State FLUSH:
//    - commit_branch=0 and commit_zero=0; flush=1 is held.
//    - ex_* inputs are ignored entirely (wrong path), including branches.
//    - cnt decrements each cycle; when cnt==0, flush drops next cycle and state returns to IDLE.
//    - Total flush high time is exactly FLUSH_DEPTH cycles.
//  - Back-to-back branches in IDLE: each is handled in its own cycle.
//    - A taken branch immediately blocks the next FLUSH_DEPTH retire slots.
//  - commit_branch is never high on two consecutive cycles following a taken branch.
//  - branch_result is only meaningful while commit_branch=1.
// STRUCTURE
//  - Shared package cpu_pkg holds:
//    - ADDR_W default and INSTR_BYTES=4.
//    - typedef enum logic {REDIR_IDLE, REDIR_FLUSH} redirect_state_t.
//    - struct commit_redirect_t {branch, zero, result}, matching the commit interface fields.
//  - One sub-module: cpu_branch_target (combinational pc+4+(imm<<2), ADDR_W wide).
//  - FSM, flush counter and stat counter live in this module.
// TESTING
//  1 Reset: hold reset=0 for 2 cycles with ex_valid=1, ex_branch=1, ex_zero=1.
//    -> all outputs 0 throughout and 1 cycle after release.
//  2 Taken branch: ex_pc=0x100, ex_imm=3, zero=1.
//    -> next cycle commit_branch=1, commit_zero=1, branch_result=0x110;
//       flush=1 for exactly 2 cycles; redirect_count=1.
//  3 Not taken: ex_pc=0x200, ex_imm=-1, zero=0.
//    -> commit_branch=1, commit_zero=0, branch_result=0x200 for 1 cycle; flush stays 0.
//  4 Wrong-path squash: taken branch, then a taken branch on each of the next 2 cycles.
//    -> only the first redirects; redirect_count=1; a third branch after flush redirects.
//  5 Wrap/saturation:
//    - ex_pc=0xFFFFFFF8, ex_imm=2 -> branch_result=0x00000004.
//    - Preload 255 taken branches -> redirect_count stays 0xFF.
//  6 Reset mid-flush: assert reset on the flush cycle 1 -> next cycle flush=0, state IDLE;
//    a branch issued after release redirects normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath width, instruction size and the
// commit-side redirect types seen by fetch.
package cpu_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int INSTR_BYTES    = 4;

    typedef enum logic {
        REDIR_IDLE,
        REDIR_FLUSH
    } redirect_state_t;

    typedef struct packed {
        logic                      branch;
        logic                      zero;
        logic [ADDR_W_DEFAULT-1:0] result;
    } commit_redirect_t;

endpackage

// File: rtl/cpu_branch_target.sv
// Branch target adder: pc + INSTR_BYTES + (imm scaled to bytes), wrapping
// silently at ADDR_W bits.
module cpu_branch_target
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] imm,
    output logic [ADDR_W-1:0] target
);

    localparam int IMM_SHIFT = $clog2(INSTR_BYTES);

    // imm is a word offset; the carry out of the sum is intentionally dropped.
    always_comb begin
        target = pc + ADDR_W'(INSTR_BYTES) + (imm << IMM_SHIFT);
    end

endmodule

// File: rtl/cpu_commit_redirect.sv
// Commit-side branch redirect: registers the redirect fields for fetch and
// holds a timed flush over the wrong-path slots after a taken branch.
module cpu_commit_redirect
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    // ex_valid qualifies all ex_* inputs for one cycle; there is no back-pressure,
    // execute retires whenever ex_valid is high and the block is in REDIR_IDLE.
    input  logic                  ex_valid,
    input  logic                  ex_branch,
    input  logic                  ex_zero,
    input  logic [ADDR_W-1:0]     ex_pc,
    input  logic [ADDR_W-1:0]     ex_imm,
    output logic                  commit_branch,
    output logic                  commit_zero,
    output logic [ADDR_W-1:0]     branch_result,
    output logic                  flush,
    output logic [CNT_W-1:0]      redirect_count,
    output redirect_state_t       state
);

    localparam int FCNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

    redirect_state_t   state_q, state_d;
    logic [FCNT_W-1:0] cnt_q, cnt_d;
    logic              branch_q, branch_d;
    logic              zero_q, zero_d;
    logic [ADDR_W-1:0] result_q, result_d;
    logic              flush_q, flush_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] target;

    cpu_branch_target #(
        .ADDR_W (ADDR_W)
    ) u_target (
        .pc     (ex_pc),
        .imm    (ex_imm),
        .target (target)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        branch_d = 1'b0;
        zero_d   = 1'b0;
        result_d = result_q;
        flush_d  = flush_q;
        count_d  = count_q;
        case (state_q)
            REDIR_IDLE: begin
                flush_d = 1'b0;
                if (ex_valid && ex_branch) begin
                    branch_d = 1'b1;
                    zero_d   = ex_zero;
                    result_d = target;
                    if (ex_zero) begin
                        // Flush rises together with the redirect strobe.
                        flush_d = 1'b1;
                        state_d = REDIR_FLUSH;
                        cnt_d   = FCNT_W'(FLUSH_DEPTH - 1);
                        if (count_q != {CNT_W{1'b1}}) begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
            end
            REDIR_FLUSH: begin
                // Wrong-path retires are dropped without inspection.
                if (cnt_q == '0) begin
                    flush_d = 1'b0;
                    state_d = REDIR_IDLE;
                end else begin
                    flush_d = 1'b1;
                    cnt_d   = cnt_q - FCNT_W'(1);
                end
            end
            default: begin
                flush_d = 1'b0;
                state_d = REDIR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= REDIR_IDLE;
            cnt_q    <= '0;
            branch_q <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
            flush_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            branch_q <= branch_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            flush_q  <= flush_d;
            count_q  <= count_d;
        end
    end

    assign commit_branch  = branch_q;
    assign commit_zero    = zero_q;
    assign branch_result  = result_q;
    assign flush          = flush_q;
    assign redirect_count = count_q;
    assign state          = state_q;

endmodule

// File: tb/tb_cpu_commit_redirect.sv
// Directed bench for cpu_commit_redirect: reset, taken/not-taken redirects,
// wrong-path squash, target wrap, counter saturation and reset mid-flush.
module tb_cpu_commit_redirect;
    import cpu_pkg::*;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 8;

    logic              clock;
    logic              reset;
    logic              ex_valid;
    logic              ex_branch;
    logic              ex_zero;
    logic [ADDR_W-1:0] ex_pc;
    logic [ADDR_W-1:0] ex_imm;
    logic              commit_branch;
    logic              commit_zero;
    logic [ADDR_W-1:0] branch_result;
    logic              flush;
    logic [CNT_W-1:0]  redirect_count;
    redirect_state_t   state;

    int tests_run;
    int tests_failed;

    cpu_commit_redirect #(
        .ADDR_W      (ADDR_W),
        .FLUSH_DEPTH (2),
        .CNT_W       (CNT_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_zero        (ex_zero),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .commit_branch  (commit_branch),
        .commit_zero    (commit_zero),
        .branch_result  (branch_result),
        .flush          (flush),
        .redirect_count (redirect_count),
        .state          (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic z,
                         input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] imm);
        ex_valid  = v;
        ex_branch = b;
        ex_zero   = z;
        ex_pc     = pc;
        ex_imm    = imm;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // One rising edge, then settle to the falling edge for sampling.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_out(input string tag, input logic cb, input logic cz,
                             input logic [ADDR_W-1:0] res, input logic fl,
                             input logic [CNT_W-1:0] cnt);
        check({tag, ".commit_branch"},  64'(commit_branch),  64'(cb));
        check({tag, ".commit_zero"},    64'(commit_zero),    64'(cz));
        check({tag, ".branch_result"},  64'(branch_result),  64'(res));
        check({tag, ".flush"},          64'(flush),          64'(fl));
        check({tag, ".redirect_count"}, 64'(redirect_count), 64'(cnt));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'd3);
        @(negedge clock);

        // 1: reset held with a taken branch on the inputs
        step();
        check_out("rst_c1", 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        step();
        check_out("rst_c2", 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        check("rst_c2.state", 64'(state), 64'(REDIR_IDLE));
        reset = 1'b1;
        idle();
        step();
        check_out("rst_rel", 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);

        // 2: taken branch 0x100 + 4 + 12 = 0x110, flush for 2 cycles
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'd3);
        step();
        check_out("taken_c0", 1'b1, 1'b1, 32'h110, 1'b1, 8'd1);
        idle();
        step();
        check_out("taken_c1", 1'b0, 1'b0, 32'h110, 1'b1, 8'd1);
        step();
        check_out("taken_c2", 1'b0, 1'b0, 32'h110, 1'b0, 8'd1);
        check("taken_c2.state", 64'(state), 64'(REDIR_IDLE));

        // 3: not taken, 0x200 + 4 - 4 = 0x200
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'hFFFF_FFFF);
        step();
        check_out("ntaken_c0", 1'b1, 1'b0, 32'h200, 1'b0, 8'd1);
        idle();
        step();
        check_out("ntaken_c1", 1'b0, 1'b0, 32'h200, 1'b0, 8'd1);

        // 4: taken branch followed by taken branches in both wrong-path slots
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'd0);
        step();
        check_out("squash_c0", 1'b1, 1'b1, 32'h304, 1'b1, 8'd2);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0400, 32'd5);
        step();
        check_out("squash_c1", 1'b0, 1'b0, 32'h304, 1'b1, 8'd2);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0440, 32'd7);
        step();
        check_out("squash_c2", 1'b0, 1'b0, 32'h304, 1'b0, 8'd2);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'd1);
        step();
        check_out("squash_c3", 1'b1, 1'b1, 32'h508, 1'b1, 8'd3);
        idle();
        step();
        step();
        check_out("squash_end", 1'b0, 1'b0, 32'h508, 1'b0, 8'd3);

        // Non-branch retire: strobe low, target register holds
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0900, 32'd9);
        step();
        check_out("nonbr", 1'b0, 1'b0, 32'h508, 1'b0, 8'd3);

        // 5a: target wraps, 0xFFFFFFF8 + 4 + 8 = 0x4
        drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'd2);
        step();
        check_out("wrap", 1'b1, 1'b0, 32'h4, 1'b0, 8'd3);

        // 5b: 252 more taken redirects bring the counter to 255
        for (int i = 0; i < 252; i++) begin
            drive(1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'd1);
            step();
            idle();
            step();
            step();
        end
        check("sat_255", 64'(redirect_count), 64'hFF);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'd0);
        step();
        check_out("sat_hold", 1'b1, 1'b1, 32'h2004, 1'b1, 8'hFF);
        idle();
        step();
        step();
        check("sat_drain.flush", 64'(flush), 64'h0);

        // 6: reset on the first flush cycle, then a normal redirect
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0600, 32'd4);
        step();
        check_out("rflush_c0", 1'b1, 1'b1, 32'h614, 1'b1, 8'hFF);
        reset = 1'b0;
        idle();
        step();
        check_out("rflush_rst", 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        check("rflush_rst.state", 64'(state), 64'(REDIR_IDLE));
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0700, 32'hFFFF_FFFE);
        step();
        check_out("rflush_after", 1'b1, 1'b1, 32'h6FC, 1'b1, 8'd1);
        idle();
        step();
        step();
        check_out("rflush_drain", 1'b0, 1'b0, 32'h6FC, 1'b0, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
